apb_master: RTL and testbench

APB4 requester for the core's memory port: takes a single load or store request from the instruction sequencer, runs the APB SETUP/ACCESS handshake, and returns a lane-aligned read word plus a one-cycle completion pulse. It sits directly downstream of the datapath. The request address is the datapath's `APB_paddr_val` and the store data is its `APB_pdata_val`. The returned `rsp_rdata` feeds the datapath's `odata`, and `rsp_valid` drives `mem_access_rdy`.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_lane_align.sv | 38 +++
 rtl/apb_master.sv | 168 ++++++++++++++++
 tb/tb_apb_master.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB4 requester: FSM state encoding,
// access-size codes and the alignment rule.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Size 2'b11 falls into the word rule, matching how the lanes treat it.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/apb_lane_align.sv
// Byte-lane steering: write strobes and replicated write data for stores,
// shift-and-mask of the read word for loads.
module apb_lane_align
  import apb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] prdata,
  output logic [3:0]  strb,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // NOTE: every signal driven here gets a value before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    shifted    = prdata >> {addr_lo, 3'b000};
    strb       = 4'b1111;
    lane_wdata = wdata;
    rdata      = shifted;
    case (size)
      SIZE_B: begin
        strb       = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        rdata      = {24'h0, shifted[7:0]};
      end
      SIZE_H: begin
        strb       = 4'b0011 << addr_lo;
        lane_wdata = {2{wdata[15:0]}};
        rdata      = {16'h0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/apb_master.sv
// APB4 requester for single load/store requests with registered outputs.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  state_t      state_q, state_d;
  logic [1:0]  size_q, addr_lo_q;
  logic        write_q;
  logic        tmo_expire;
  logic        accept;
  logic [1:0]  sel_size, sel_lo;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata, lane_rdata;

  logic        psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_err_d;
  logic [31:0] paddr_d, pwdata_d, rsp_rdata_d;
  logic [3:0]  pstrb_d;

  // Lanes use the live request in IDLE (to register PWDATA/PSTRB for SETUP)
  // and the latched request afterwards (to align PRDATA).
  assign sel_size = (state_q == ST_IDLE) ? req_size       : size_q;
  assign sel_lo   = (state_q == ST_IDLE) ? req_addr[1:0]  : addr_lo_q;

  apb_lane_align u_lane (
    .size       (sel_size),
    .addr_lo    (sel_lo),
    .wdata      (req_wdata),
    .prdata     (PRDATA),
    .strb       (lane_strb),
    .lane_wdata (lane_wdata),
    .rdata      (lane_rdata)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TMO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TMO_W   = (TMO_RAW < 8) ? 8 : ((TMO_RAW > 16) ? 16 : TMO_RAW);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_q <= '0;
    else if (state_q == ST_SETUP)
      tmo_q <= TMO_W'(TIMEOUT_CYCLES);
    else if (state_q == ST_ACCESS && !PREADY && tmo_q != '0)
      tmo_q <= tmo_q - 1'b1;
  end

  // Expiry is the ACCESS cycle whose decrement would reach zero.
  assign tmo_expire = (state_q == ST_ACCESS) && !PREADY && (tmo_q <= TMO_W'(1));
`else
  assign tmo_expire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req) state_d = is_misaligned(req_size, req_addr[1:0]) ? ST_DONE : ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (PREADY || tmo_expire) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    accept      = (state_q == ST_IDLE) && (state_d == ST_SETUP);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_DONE);
    paddr_d     = '0;
    pwrite_d    = 1'b0;
    pwdata_d    = '0;
    pstrb_d     = '0;
    if (accept) begin
      paddr_d  = {req_addr[31:2], 2'b00};
      pwrite_d = req_write;
      if (req_write) begin
        pwdata_d = lane_wdata;
        pstrb_d  = lane_strb;
      end
    end else if (psel_d) begin
      paddr_d  = PADDR;
      pwrite_d = PWRITE;
      pwdata_d = PWDATA;
      pstrb_d  = PSTRB;
    end
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE:   rsp_err_d = req && is_misaligned(req_size, req_addr[1:0]);
      ST_ACCESS: begin
        if (PREADY) begin
          rsp_err_d = PSLVERR;
          if (!PSLVERR && !write_q) rsp_rdata_d = lane_rdata;
        end else begin
          rsp_err_d = tmo_expire;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q    <= SIZE_B;
      addr_lo_q <= 2'b00;
      write_q   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        size_q    <= req_size;
        addr_lo_q <= req_addr[1:0];
        write_q   <= req_write;
      end
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      PSTRB     <= pstrb_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a negedge APB slave model with configurable
// wait states and a response scoreboard filled as each request is issued.
module tb_apb_master;
  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        busy, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;

  int wait_states = 0;
  int acc_cnt = 0;
  logic slave_err = 1'b0;
  int total = 0, passed = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  apb_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  // Slave: ready after wait_states ACCESS cycles; decided away from the rising edge.
  always @(negedge clk) begin
    if (PSEL && PENABLE) begin
      PREADY = (acc_cnt >= wait_states);
      acc_cnt++;
    end else begin
      PREADY = 1'b0;
      acc_cnt = 0;
    end
    PSLVERR = PREADY && slave_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_xfer(input string tag, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                          input logic [31:0] rd, input logic serr,
                          input logic [31:0] exp_paddr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_pwdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input int exp_psel);
    int n = 0, psel_cycles = 0, hold_bad = 0;
    bit seen = 0;
    exp_t e;
    wait_states = waits;
    PRDATA = rd;
    slave_err = serr;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    req = 1'b1; req_write = wr; req_size = size; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req = 1'b0;
    while (!seen && n < 40) begin
      n++;
      if (PSEL) begin
        psel_cycles++;
        if (PADDR !== exp_paddr || PSTRB !== exp_strb || PWDATA !== exp_pwdata || PWRITE !== wr)
          hold_bad++;
      end
      if (rsp_valid) begin
        seen = 1;
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        if (sb_q.size() == 0) begin
          check({tag, " scoreboard empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check({tag, " rdata"}, rsp_rdata, e.rdata);
          check({tag, " err"}, 32'(rsp_err), 32'(e.err));
        end
      end else begin
        @(negedge clk);
      end
    end
    check({tag, " rsp_seen"}, 32'(seen), 32'd1);
    check({tag, " psel_cycles"}, 32'(psel_cycles), 32'(exp_psel));
    check({tag, " held_signals"}, 32'(hold_bad), 32'd0);
    @(negedge clk);
    check({tag, " idle_after"}, {23'h0, rsp_valid, busy, PSEL, PENABLE, PWRITE, PSTRB}, 32'h0);
    check({tag, " paddr_idle"}, PADDR, 32'h0);
  endtask

  initial begin
    #12;
    check("reset ctrl", {22'h0, rsp_valid, rsp_err, busy, PSEL, PENABLE, PWRITE, PSTRB}, 32'h0);
    check("reset paddr", PADDR, 32'h0);
    check("reset pwdata", PWDATA, 32'h0);
    check("reset rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_xfer("word_load", 1'b0, SIZE_W, 32'h1000_0004, 32'h0, 0, 32'hDEAD_BEEF, 1'b0,
             32'h1000_0004, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 2);
    run_xfer("byte_store", 1'b1, SIZE_B, 32'h0000_2003, 32'h0000_00A5, 2, 32'hFFFF_FFFF, 1'b0,
             32'h0000_2000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0, 5, 4);
    run_xfer("half_load", 1'b0, SIZE_H, 32'h0000_2002, 32'h0, 0, 32'h8001_1234, 1'b0,
             32'h0000_2000, 4'b0000, 32'h0, 32'h0000_8001, 1'b0, 3, 2);
    run_xfer("misaligned_word", 1'b0, SIZE_W, 32'h0000_0001, 32'h0, 0, 32'h5555_5555, 1'b0,
             32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 0);
    run_xfer("pslverr", 1'b0, SIZE_W, 32'h0000_3000, 32'h0, 1, 32'h1234_5678, 1'b1,
             32'h0000_3000, 4'b0000, 32'h0, 32'h0, 1'b1, 4, 3);
    run_xfer("byte_load", 1'b0, SIZE_B, 32'h0000_4001, 32'h0, 0, 32'h1122_3344, 1'b0,
             32'h0000_4000, 4'b0000, 32'h0, 32'h0000_0033, 1'b0, 3, 2);
    run_xfer("half_store", 1'b1, SIZE_H, 32'h0000_4002, 32'hFFFF_BEEF, 1, 32'h0, 1'b0,
             32'h0000_4000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 4, 3);
    run_xfer("size3_store", 1'b1, 2'b11, 32'h0000_5000, 32'hCAFE_F00D, 0, 32'h0, 1'b0,
             32'h0000_5000, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 3, 2);
    run_xfer("misaligned_half", 1'b1, SIZE_H, 32'h0000_5001, 32'h0000_1111, 0, 32'h0, 1'b0,
             32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 0);
`ifdef APB_TIMEOUT_EN
    run_xfer("timeout", 1'b0, SIZE_W, 32'h0000_7000, 32'h0, 1000, 32'h7777_7777, 1'b0,
             32'h0000_7000, 4'b0000, 32'h0, 32'h0, 1'b1, 6, 5);
`endif

    // Reset asserted in the middle of a stalled ACCESS phase.
    wait_states = 5;
    PRDATA = 32'h0BAD_F00D;
    slave_err = 1'b0;
    @(negedge clk);
    req = 1'b1; req_write = 1'b0; req_size = SIZE_W; req_addr = 32'h0000_6000;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 10 && !PENABLE; i++) @(negedge clk);
    check("rst_mid in_access", 32'(PENABLE), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid async", {28'h0, PSEL, PENABLE, busy, rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer("after_reset", 1'b0, SIZE_W, 32'h0000_6000, 32'h0, 0, 32'h0BAD_F00D, 1'b0,
             32'h0000_6000, 4'b0000, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
